// File: rtl/col_feeder_if.sv
// Upstream pixel stream into col_feeder: a valid/ready handshake carrying one pixel per beat.
// The source drives the master modport and col_feeder takes the slave modport.
interface col_feeder_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/col_feeder.sv
// Column feeder: writes KSIZE pixels per column into the global buffer, then waits for the consumer to read it.
// Optional feature: define COL_FEEDER_ABORT_EN to add a synchronous abort input that returns the FSM to IDLE.
module col_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int KSIZE      = 5,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  go,
  input  logic [5:0]            num_cols,
`ifdef COL_FEEDER_ABORT_EN
  input  logic                  abort,
`endif
  col_feeder_if.slave           up,
  input  logic                  rd_ack,
  output logic                  start,
  output logic                  wr_ctrl_g,
  output logic [ADDR_W-1:0]     adrs_out,
  output logic [DATA_WIDTH-1:0] g_data,
  output logic                  col_valid,
  output logic [5:0]            round,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(KSIZE - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        ncols;
  logic              s_ready_r;
  logic              accept;
  logic              abort_i;

`ifdef COL_FEEDER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // s_ready_r is high exactly while in FILL, so this is the accept condition.
  assign accept     = up.s_valid && s_ready_r;
  assign up.s_ready = s_ready_r;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      addr      <= '0;
      ncols     <= '0;
      round     <= '0;
      s_ready_r <= 1'b0;
      start     <= 1'b0;
      wr_ctrl_g <= 1'b0;
      adrs_out  <= '0;
      g_data    <= '0;
      col_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      start     <= 1'b0;
      done      <= 1'b0;
      wr_ctrl_g <= 1'b0;

      if (abort_i) begin
        state     <= IDLE;
        addr      <= '0;
        col_valid <= 1'b0;
        s_ready_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              ncols     <= (num_cols == 6'd0) ? 6'd1 : num_cols;
              round     <= 6'd1;
              addr      <= '0;
              start     <= 1'b1;
              s_ready_r <= 1'b1;
              state     <= FILL;
            end
          end

          FILL: begin
            if (accept) begin
              wr_ctrl_g <= 1'b1;
              adrs_out  <= addr;
              g_data    <= up.s_data;
              addr      <= addr + 1'b1;
              // Final pixel: the column becomes visible on the same edge as its last strobe.
              if (addr == LAST_ADDR) begin
                s_ready_r <= 1'b0;
                col_valid <= 1'b1;
                state     <= WAIT_ACK;
              end
            end
          end

          WAIT_ACK: begin
            if (rd_ack) begin
              col_valid <= 1'b0;
              if (round < ncols) begin
                round     <= round + 6'd1;
                addr      <= '0;
                s_ready_r <= 1'b1;
                state     <= FILL;
              end else begin
                done      <= 1'b1;
                s_ready_r <= 1'b0;
                state     <= IDLE;
              end
            end
          end

          default: begin
            state     <= IDLE;
            addr      <= '0;
            s_ready_r <= 1'b0;
            col_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_col_feeder.sv
// Self-checking bench for col_feeder: directed frames with randomized pixels, gaps and ack delays.
// Expected values come from a column/frame-level model of the pixel-to-buffer transfer.
module tb_col_feeder;
  localparam int DATA_WIDTH = 16;
  localparam int KSIZE      = 5;
  localparam int ADDR_W     = 3;

  logic                  clk      = 1'b0;
  logic                  nrst     = 1'b1;
  logic                  go       = 1'b0;
  logic                  rd_ack   = 1'b0;
  logic [5:0]            num_cols = 6'd0;
  logic                  start;
  logic                  wr_ctrl_g;
  logic [ADDR_W-1:0]     adrs_out;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  col_valid;
  logic [5:0]            round;
  logic                  done;
`ifdef COL_FEEDER_ABORT_EN
  logic                  abort = 1'b0;
`endif

  col_feeder_if #(.DATA_WIDTH(DATA_WIDTH)) up ();

  int checks     = 0;
  int errors     = 0;
  int strobe_cnt = 0;
  int done_cnt   = 0;
  logic [ADDR_W-1:0]     last_adr  = '0;
  logic [DATA_WIDTH-1:0] last_data = '0;

  always #5 clk = ~clk;

  col_feeder #(
    .DATA_WIDTH(DATA_WIDTH),
    .KSIZE     (KSIZE),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .go       (go),
    .num_cols (num_cols),
`ifdef COL_FEEDER_ABORT_EN
    .abort    (abort),
`endif
    .up       (up),
    .rd_ack   (rd_ack),
    .start    (start),
    .wr_ctrl_g(wr_ctrl_g),
    .adrs_out (adrs_out),
    .g_data   (g_data),
    .col_valid(col_valid),
    .round    (round),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (wr_ctrl_g) strobe_cnt++;
  endtask

  task automatic start_frame(input int n);
    up.s_valid = 1'($urandom);
    up.s_data  = DATA_WIDTH'($urandom);
    go         = 1'b1;
    num_cols   = 6'(n);
    step();
    go       = 1'b0;
    num_cols = 6'($urandom);
    check("go_start", 32'(start), 32'd1);
    check("go_round", 32'(round), 32'd1);
    check("go_ready", 32'(up.s_ready), 32'd1);
    check("go_colv", 32'(col_valid), 32'd0);
    check("go_wr", 32'(wr_ctrl_g), 32'd0);
    check("go_done", 32'(done), 32'd0);
  endtask

  // gap: 0 back-to-back, 1 valid toggling 1,0,1,0, 2 random gaps
  task automatic fill_column(input int c, input int gap, input bit fixed, input bit poke, input int stop);
    int k;
    int idle;
    bit v;
    logic [DATA_WIDTH-1:0] d;
    k = 0;
    for (int i = 0; i < stop; i++) begin
      idle = 0;
      v    = 1'b0;
      while (!v) begin
        case (gap)
          0:       v = 1'b1;
          1:       v = (k % 2 == 0);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        if (idle >= 3) v = 1'b1;
        k++;
        d = fixed ? DATA_WIDTH'(8'h11 + i) : DATA_WIDTH'($urandom);
        up.s_valid = v;
        up.s_data  = d;
        if (poke && $urandom_range(0, 3) == 0) begin
          go       = 1'b1;
          num_cols = 6'($urandom);
          rd_ack   = 1'b1;
        end
        step();
        go     = 1'b0;
        rd_ack = 1'b0;
        check("fill_round", 32'(round), 32'(c));
        check("fill_start", 32'(start), 32'd0);
        if (v) begin
          check("strobe", 32'(wr_ctrl_g), 32'd1);
          check("strobe_adrs", 32'(adrs_out), 32'(i));
          check("strobe_data", 32'(g_data), 32'(d));
          last_adr  = ADDR_W'(i);
          last_data = d;
          if (i == KSIZE - 1) begin
            check("last_colv", 32'(col_valid), 32'd1);
            check("last_ready", 32'(up.s_ready), 32'd0);
          end else begin
            check("mid_colv", 32'(col_valid), 32'd0);
            check("mid_ready", 32'(up.s_ready), 32'd1);
          end
        end else begin
          check("gap_wr", 32'(wr_ctrl_g), 32'd0);
          check("gap_adrs", 32'(adrs_out), 32'(last_adr));
          check("gap_data", 32'(g_data), 32'(last_data));
          check("gap_ready", 32'(up.s_ready), 32'd1);
          idle++;
        end
      end
    end
    up.s_valid = 1'b0;
  endtask

  task automatic wait_ack(input int c, input int n, input int dly);
    for (int j = 0; j < dly; j++) begin
      up.s_valid = 1'($urandom);
      up.s_data  = DATA_WIDTH'($urandom);
      go         = 1'($urandom);
      step();
      go = 1'b0;
      check("wait_ready", 32'(up.s_ready), 32'd0);
      check("wait_colv", 32'(col_valid), 32'd1);
      check("wait_wr", 32'(wr_ctrl_g), 32'd0);
      check("wait_round", 32'(round), 32'(c));
      check("wait_done", 32'(done), 32'd0);
    end
    rd_ack     = 1'b1;
    up.s_valid = 1'($urandom);
    step();
    rd_ack     = 1'b0;
    up.s_valid = 1'b0;
    check("ack_colv", 32'(col_valid), 32'd0);
    check("ack_wr", 32'(wr_ctrl_g), 32'd0);
    if (c < n) begin
      check("ack_round", 32'(round), 32'(c + 1));
      check("ack_ready", 32'(up.s_ready), 32'd1);
      check("ack_done", 32'(done), 32'd0);
    end else begin
      check("final_done", 32'(done), 32'd1);
      check("final_ready", 32'(up.s_ready), 32'd0);
      check("final_round", 32'(round), 32'(c));
    end
  endtask

  task automatic run_frame(input int n, input int gap, input int dly, input bit fixed, input bit poke);
    int ne;
    int s0;
    int d0;
    ne = (n == 0) ? 1 : n;
    s0 = strobe_cnt;
    d0 = done_cnt;
    start_frame(n);
    for (int c = 1; c <= ne; c++) begin
      fill_column(c, gap, fixed && (c == 1), poke, KSIZE);
      wait_ack(c, ne, dly);
    end
    step();
    check("post_done", 32'(done), 32'd0);
    check("post_round", 32'(round), 32'(ne));
    check("post_ready", 32'(up.s_ready), 32'd0);
    check("post_colv", 32'(col_valid), 32'd0);
    check("frame_strobes", 32'(strobe_cnt - s0), 32'(ne * KSIZE));
    check("frame_dones", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_wr"}, 32'(wr_ctrl_g), 32'd0);
    check({tag, "_adrs"}, 32'(adrs_out), 32'd0);
    check({tag, "_data"}, 32'(g_data), 32'd0);
    check({tag, "_colv"}, 32'(col_valid), 32'd0);
    check({tag, "_round"}, 32'(round), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ready"}, 32'(up.s_ready), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    up.s_valid = 1'b0;
    up.s_data  = '0;
    #2 nrst = 1'b0;
    #2;
    check_all_zero("reset");
    step();
    step();
    nrst = 1'b1;

    // IDLE ignores upstream traffic until go
    up.s_valid = 1'b1;
    up.s_data  = DATA_WIDTH'($urandom);
    for (int j = 0; j < 3; j++) begin
      step();
      check("idle_ready", 32'(up.s_ready), 32'd0);
      check("idle_wr", 32'(wr_ctrl_g), 32'd0);
      check("idle_start", 32'(start), 32'd0);
    end
    up.s_valid = 1'b0;

    run_frame(1, 0, 0, 1'b1, 1'b0);
    run_frame(3, 2, 4, 1'b0, 1'b0);
    run_frame(2, 1, 1, 1'b0, 1'b0);
    run_frame(2, 2, 2, 1'b0, 1'b1);
    run_frame(0, 0, 0, 1'b0, 1'b0);
    for (int f = 0; f < 4; f++)
      run_frame(int'($urandom_range(1, 4)), 2, int'($urandom_range(0, 3)), 1'b0, 1'b1);

    // Reset in the middle of the second column
    start_frame(3);
    fill_column(1, 0, 1'b0, 1'b0, KSIZE);
    wait_ack(1, 3, 0);
    fill_column(2, 0, 1'b0, 1'b0, 3);
    nrst = 1'b0;
    #1;
    check_all_zero("midrst");
    last_adr  = '0;
    last_data = '0;
    step();
    step();
    nrst       = 1'b1;
    up.s_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      step();
      check("rst_idle_ready", 32'(up.s_ready), 32'd0);
      check("rst_idle_wr", 32'(wr_ctrl_g), 32'd0);
      check("rst_idle_round", 32'(round), 32'd0);
    end
    up.s_valid = 1'b0;
    run_frame(2, 2, 1, 1'b0, 1'b0);

`ifdef COL_FEEDER_ABORT_EN
    start_frame(2);
    fill_column(1, 0, 1'b0, 1'b0, KSIZE);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_colv", 32'(col_valid), 32'd0);
    check("abort_ready", 32'(up.s_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wr", 32'(wr_ctrl_g), 32'd0);
    rd_ack     = 1'b1;
    up.s_valid = 1'b1;
    step();
    rd_ack     = 1'b0;
    up.s_valid = 1'b0;
    check("abort_idle_done", 32'(done), 32'd0);
    check("abort_idle_ready", 32'(up.s_ready), 32'd0);
    run_frame(1, 2, 1, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/col_feeder.md
COL_FEEDER -- requirements
Module: col_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel width in bits.
REQ-002 SHALL have parameter KSIZE, default 5, pixels per window column (global-buffer depth).
REQ-003 SHALL have parameter ADDR_W, default 3, width of the buffer address.
REQ-004 SHALL have port clk  input  1  clock, rising-edge active.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port go  input  1  single-cycle request to start a frame of columns.
REQ-007 SHALL have port num_cols  input  6  columns per frame, sampled on the cycle go is accepted.
REQ-008 SHALL have port s_valid  input  1  upstream pixel valid.
REQ-009 SHALL have port s_data  input  DATA_WIDTH  upstream pixel.
REQ-010 SHALL have port s_ready  output  1  pixel accepted when s_valid and s_ready are both high.
REQ-011 SHALL have port rd_ack  input  1  consumer has read the global buffer (consumer r_ctrl_g).
REQ-012 SHALL have port start  output  1  one-cycle pulse to the consumer at frame start.
REQ-013 SHALL have port wr_ctrl_g  output  1  global-buffer write strobe.
REQ-014 SHALL have port adrs_out  output  ADDR_W  global-buffer write address.
REQ-015 SHALL have port g_data  output  DATA_WIDTH  global-buffer write data.
REQ-016 SHALL have port col_valid  output  1  full column held in buffer, awaiting rd_ack.
REQ-017 SHALL have port round  output  6  current column index, 1-based.
REQ-018 SHALL have port done  output  1  one-cycle pulse when the last column is acknowledged.

Function
REQ-019 SHALL implement FSM states IDLE, FILL and WAIT_ACK; all outputs SHALL be registered.
REQ-020 IDLE: s_ready=0; when go=1, SHALL latch num_cols (0 treated as 1), set round=1, addr=0, pulse start for one cycle and enter FILL.
REQ-021 FILL: s_ready=1; on each accept, the next cycle SHALL carry wr_ctrl_g=1, adrs_out=addr, g_data=s_data for exactly one cycle, and addr SHALL increment.
REQ-022 Cycles without an accept SHALL leave wr_ctrl_g=0; adrs_out and g_data SHALL hold their last values.
REQ-023 An accept with addr==KSIZE-1 SHALL move the FSM to WAIT_ACK on the same edge that raises the final write strobe; col_valid SHALL rise on that edge.
REQ-024 WAIT_ACK: s_ready=0 and col_valid=1; rd_ack SHALL be ignored in IDLE and FILL.
REQ-025 rd_ack in WAIT_ACK with round<num_cols SHALL increment round, clear addr, drop col_valid and enter FILL.
REQ-026 rd_ack in WAIT_ACK with round==num_cols SHALL pulse done for one cycle, drop col_valid and enter IDLE; round SHALL hold until the next go.
REQ-027 go SHALL be ignored outside IDLE.
REQ-028 s_data SHALL pass unmodified with no arithmetic; round SHALL never wrap, being bounded by num_cols<=63.

Reset
REQ-029 nrst low SHALL asynchronously force state=IDLE, addr=0, round=0, latched num_cols=0 and all outputs to 0, including mid-column.
REQ-030 After nrst deasserts, the block SHALL wait in IDLE for a new go; a partially written column SHALL be discarded.

Configuration
REQ-031 With macro COL_FEEDER_ABORT_EN defined, an extra input abort (1 bit) SHALL synchronously return any state to IDLE on the next edge, clearing addr, col_valid, s_ready and wr_ctrl_g, without a done pulse.
REQ-032 Without COL_FEEDER_ABORT_EN, the abort port SHALL not exist and the FSM SHALL leave a frame only via REQ-026 or reset.

Verification
REQ-033 go with num_cols=1, pixels 0x11..0x15 streamed back-to-back -> strobes at adrs 0..4 on 5 consecutive cycles; col_valid=1; rd_ack -> done pulse, state IDLE.
REQ-034 num_cols=3 with rd_ack delayed 4 cycles per column -> s_ready=0 while waiting; round goes 1,2,3; 15 strobes total; exactly one done.
REQ-035 s_valid toggled 1,0,1,0 during FILL -> wr_ctrl_g only on the cycles after accepts; adrs_out stays contiguous 0..4.
REQ-036 go and rd_ack pulsed during FILL -> no effect; round and addr unchanged.
REQ-037 nrst asserted after 3 pixels of column 2 -> all outputs 0 immediately; the next go restarts at round=1, adrs 0.
REQ-038 COL_FEEDER_ABORT_EN: abort in WAIT_ACK -> IDLE next cycle, col_valid=0, no done pulse.
